// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states and the
// funct3 access-size encodings.
package lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/halfword lane addressed by
// offset from a memory word and sign- or zero-extends it to 32 bits.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[offset];
    // offset[0] is always clear for legal halfword accesses
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = '0;
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   value = {24'd0, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_HU:   value = {16'd0, half_sel};
            F3_W:    value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one byte/halfword/word load or store on a
// ready-handshake memory, stalls until it completes and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [2:0]              Funct3,
    input  logic [DATA_WIDTH-1:0]   Addr,
    input  logic [DATA_WIDTH-1:0]   WrData,
    output logic                    Stall,
    output logic                    Done,
    output logic                    AccessErr,
    output logic [DATA_WIDTH-1:0]   RdData,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  off_reg;
    logic        we_reg;
    logic        err_reg;
    logic [31:0] rd_data_reg;

    logic        request;
    logic        is_store;
    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_value;

    assign request  = MemRead | MemWrite;
    assign is_store = MemWrite;

    // Unsigned variants only make sense for loads; alignment is natural size
    always_comb begin
        legal = 1'b0;
        case (Funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~Addr[0];
            F3_W:    legal = (Addr[1:0] == 2'b00);
            F3_BU:   legal = ~is_store;
            F3_HU:   legal = ~is_store & ~Addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = WrData;
        case (Funct3)
            F3_B, F3_BU: begin
                be_next    = 4'b0001 << Addr[1:0];
                wdata_next = {4{WrData[7:0]}};
            end
            F3_H, F3_HU: begin
                be_next    = 4'b0011 << Addr[1:0];
                wdata_next = {2{WrData[15:0]}};
            end
            F3_W:    be_next = 4'b1111;
            default: be_next = 4'b0000;
        endcase
    end

    load_align u_load_align (
        .word   (mem_rdata),
        .offset (off_reg),
        .funct3 (f3_reg),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            be_reg      <= '0;
            wdata_reg   <= '0;
            f3_reg      <= '0;
            off_reg     <= '0;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && request) begin
                addr_reg  <= {Addr[31:2], 2'b00};
                be_reg    <= be_next;
                wdata_reg <= wdata_next;
                f3_reg    <= Funct3;
                off_reg   <= Addr[1:0];
                we_reg    <= is_store;
                err_reg   <= ~legal;
                if (!legal) begin
                    rd_data_reg <= '0;
                end
            end
            if (state_reg == REQ && mem_ready) begin
                rd_data_reg <= we_reg ? 32'd0 : load_value;
            end
        end
    end

    // DONE ignores the inputs: the pipeline still presents the finished instruction
    always_comb begin
        state_next = state_reg;
        Stall      = 1'b0;
        Done       = 1'b0;
        AccessErr  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                Stall = request;
                if (request) begin
                    state_next = legal ? REQ : DONE;
                end
            end
            REQ: begin
                Stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_reg;
                mem_addr  = addr_reg;
                mem_be    = be_reg;
                mem_wdata = wdata_reg;
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                AccessErr  = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign RdData = rd_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven accesses against a
// handshake memory model with a scoreboard, plus reset-in-REQ and back-to-back sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WrData;
    logic        Stall, Done, AccessErr;
    logic [31:0] RdData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .Addr      (Addr),
        .WrData    (WrData),
        .Stall     (Stall),
        .Done      (Done),
        .AccessErr (AccessErr),
        .RdData    (RdData),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_cyc;
        logic        exp_err;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Funct3   = 3'b000;
        Addr     = 32'd0;
        WrData   = 32'd0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        int   cyc;
        int   reqc;
        bit   seen_done;
        exp_t e;
        exp_t got;
        @(negedge clk);
        MemRead   = v.rd;
        MemWrite  = v.wr;
        Funct3    = v.f3;
        Addr      = v.addr;
        WrData    = v.wdata;
        mem_rdata = v.rdata;
        mem_ready = 1'b0;
        #1;
        chk("stall_accept", {31'd0, Stall}, 32'd1);
        chk("req_in_idle", {31'd0, mem_req}, 32'd0);
        e.idx = idx;
        e.rd  = v.exp_rd;
        e.err = v.exp_err;
        e.lat = v.exp_err ? 1 : 2 + v.wait_cyc;
        exp_q.push_back(e);
        cyc       = 0;
        reqc      = 0;
        seen_done = 0;
        while (!seen_done && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (Done) begin
                seen_done = 1;
                mem_ready = 1'b0;
                got = exp_q.pop_front();
                chk("rd_data", RdData, got.rd);
                chk("access_err", {31'd0, AccessErr}, {31'd0, got.err});
                chk("latency", cyc, got.lat);
                chk("req_in_done", {31'd0, mem_req}, 32'd0);
                chk("stall_in_done", {31'd0, Stall}, 32'd0);
            end else begin
                chk("stall_req", {31'd0, Stall}, 32'd1);
                chk("mem_req", {31'd0, mem_req}, {31'd0, !v.exp_err});
                chk("mem_we", {31'd0, mem_we}, {31'd0, v.exp_we});
                chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                chk("mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
                chk("mem_wdata", mem_wdata, v.exp_wdata);
                mem_ready = (reqc >= v.wait_cyc);
                reqc++;
            end
        end
        if (!seen_done) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: vector %0d got no Done within 20 cycles, expected %0d", idx, e.lat);
            void'(exp_q.pop_front());
        end
        // Request still held across DONE; it must not be re-issued
        @(posedge clk);
        @(negedge clk);
        chk("no_reissue_req", {31'd0, mem_req}, 32'd0);
        chk("no_reissue_done", {31'd0, Done}, 32'd0);
        chk("rd_data_held", RdData, v.exp_rd);
        drive_idle();
        #1;
        chk("stall_idle", {31'd0, Stall}, 32'd0);
        $display("vec %0d: rd=%0b wr=%0b f3=%03b addr=0x%08h -> RdData=0x%08h err=%0b cycles=%0d",
                 idx, v.rd, v.wr, v.f3, v.addr, RdData, v.exp_err, cyc);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int wait_cyc,
                                input logic err, input logic we, input logic [3:0] be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.wait_cyc = wait_cyc; v.exp_err = err; v.exp_we = we;
        v.exp_be = be; v.exp_wdata = exp_wdata; v.exp_rd = exp_rd;
        return v;
    endfunction

    initial begin
        //            rd wr f3      addr          wdata         rdata         w  err we be       exp_wdata     exp_rd
        vecs[0]  = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        vecs[1]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80);
        vecs[2]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 0, 0, 4'b1000, 32'h0,        32'h0000_0080);
        vecs[3]  = mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 0, 0, 0, 4'b1100, 32'h0,        32'h0000_80FF);
        vecs[4]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 1, 0, 0, 4'b1100, 32'h0,        32'hFFFF_80FF);
        vecs[5]  = mk(1, 0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_7FFF, 0, 0, 0, 4'b0011, 32'h0,        32'h0000_7FFF);
        vecs[6]  = mk(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'hFFFF_FFFF, 0, 1, 0, 4'b0000, 32'h0,        32'h0);
        vecs[7]  = mk(1, 0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 2, 0, 0, 4'b0001, 32'h0,        32'h0000_007F);
        vecs[8]  = mk(1, 0, 3'b001, 32'h0000_0101, 32'h0,        32'hFFFF_FFFF, 0, 1, 0, 4'b0000, 32'h0,        32'h0);
        vecs[9]  = mk(0, 1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h0,        3, 0, 1, 4'b0010, 32'hABAB_ABAB, 32'h0);
        vecs[10] = mk(0, 1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 32'h0,        0, 0, 1, 4'b1100, 32'hCDEF_CDEF, 32'h0);
        vecs[11] = mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0);
        vecs[12] = mk(0, 1, 3'b100, 32'h0000_0010, 32'h0000_00AA, 32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0);
        vecs[13] = mk(1, 1, 3'b010, 32'h0000_0040, 32'h1122_3344, 32'h5555_5555, 0, 0, 1, 4'b1111, 32'h1122_3344, 32'h0);
        vecs[14] = mk(1, 0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0);
        vecs[15] = mk(1, 0, 3'b101, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0);
        vecs[16] = mk(1, 0, 3'b000, 32'h0000_0301, 32'h0,        32'h1234_C5FF, 1, 0, 0, 4'b0010, 32'h0,        32'hFFFF_FFC5);

        drive_idle();
        reset     = 1'b1;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_err", {31'd0, AccessErr}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rddata", RdData, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], i);
        end

        // Reset while waiting in REQ with mem_ready low abandons the access
        @(negedge clk);
        MemRead   = 1'b1;
        Funct3    = 3'b010;
        Addr      = 32'h0000_0300;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstreq_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        chk("rstreq_req_after", {31'd0, mem_req}, 32'd0);
        chk("rstreq_stall_after", {31'd0, Stall}, 32'd0);
        chk("rstreq_done_after", {31'd0, Done}, 32'd0);
        reset = 1'b0;
        $display("seq reset-in-REQ: mem_req=%0b Stall=%0b", mem_req, Stall);
        apply(mk(0, 1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 4'b1111, 32'hCAFE_F00D, 32'h0), 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the ALU: takes the ALU result as effective address plus the rs2 store data, and runs one byte/halfword/word load or store against a ready-handshake data memory. It stalls the pipeline until the access completes, then presents the sign- or zero-extended load value to write-back. Misaligned accesses and unsupported funct3 codes never reach memory; they are flagged as an error instead.

## Interface
- DATA_WIDTH, 32, data and address width (only 32 supported)
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- MemRead  in  1  load request from EX
- MemWrite  in  1  store request from EX; wins if both are high
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU and HU are loads only)
- Addr  in  32  effective address (ALU result)
- WrData  in  32  store data (rs2)
- Stall  out  1  freeze upstream pipeline
- Done  out  1  one-cycle pulse when the access finishes
- AccessErr  out  1  one-cycle pulse with Done on a misaligned or illegal access
- RdData  out  32  extended load data; valid while Done=1 and held afterwards
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address ({Addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word
- mem_ready  in  1  memory completes the request this cycle

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, request (MemRead|MemWrite) and legal: latch address, byte enables, write data, funct3 and direction; go to REQ.
- IDLE, request and illegal: go to DONE with the error flag set; no mem_req is issued.
- Illegal cases: H/HU with Addr[0]=1; W with Addr[1:0]≠0; Funct3 ∈ {011,110,111}; BU/HU on a store.
- REQ: drive mem_req=1 from the latched registers. On mem_ready, capture the extended mem_rdata (loads) and go to DONE. Otherwise stay in REQ with all outputs stable.
- DONE: Done=1, Stall=0. Inputs are ignored because they still hold the same instruction. Always go to IDLE.
- Stall = (IDLE & request) | REQ.
- mem_be:
  - B: 0001<<Addr[1:0]
  - H: 0011<<Addr[1:0]
  - W: 1111
  - loads also drive the matching mem_be
- mem_wdata:
  - B: {4{WrData[7:0]}}
  - H: {2{WrData[15:0]}}
  - W: WrData
- Load extraction: select the byte or halfword lane by the latched Addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend.
- Stores and errors set RdData to 0.

## Timing
- Reset values: state IDLE; Stall, Done, AccessErr, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, RdData = 0.
- Minimum latency, with mem_ready high in the first REQ cycle:
  - accept cycle T: Stall=1
  - T+1: REQ, Stall=1
  - T+2: Done=1, Stall=0
- Each extra wait cycle of mem_ready adds one cycle.
- Error latency: accept T (Stall=1), T+1 Done=AccessErr=1.
- Memory outputs change only on the IDLE→REQ edge and return to 0 when leaving REQ.
- mem_ready outside REQ is ignored.
- Reset in any state: IDLE on the next edge and mem_req low. An outstanding memory transaction is abandoned; memory must drop it.
- Back-to-back: the next request cannot be accepted before the cycle after DONE, so the minimum spacing is 3 cycles.

## Structure
- lsu_pkg holds:
  - state enum (IDLE, REQ, DONE)
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
- One combinational sub-module, load_align: (word, offset, funct3) → extended 32-bit value. It is reusable and unit-testable on its own.
- Byte-enable and store-replication logic stays inline.

## Test plan
- LW Addr=0x100, mem_rdata=0xDEADBEEF, mem_ready high in REQ → mem_be=1111, mem_addr=0x100, Done at T+2, RdData=0xDEADBEEF, Stall high for exactly 2 cycles.
- LB Addr=0x103, mem_rdata=0x80FFFFFF → RdData=0xFFFFFF80. LBU same → 0x00000080. LHU Addr=0x102, same word → 0x000080FF.
- SB Addr=0x201, WrData=0x123456AB, mem_ready delayed 3 cycles → mem_we=1, mem_be=0010, mem_wdata=0xABABABAB held stable through the wait, Done at T+5.
- LW Addr=0x102 and LH Addr=0x101 → no mem_req, Done=AccessErr=1 at T+1, RdData=0.
- reset asserted in REQ while mem_ready low → mem_req=0 and Stall=0 next cycle; a following SW Addr=0x8 completes normally with mem_be=1111.
- MemRead=MemWrite=1, Funct3=010 → treated as a store (mem_we=1). A request held during DONE must not be re-issued.
